mm_modexp_ctrl: RTL

//  Sequencer computing r = b^e mod m by left-to-right binary square-and-multiply.

---
 rtl/mm_pkg.sv | 15 +
 rtl/mm_modexp_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation sequencer.
package mm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SQR,
      MUL,
      OUT
   } state_t;

   // Width limit imposed by the multiplier core on the operand width.
   localparam int unsigned K_LIMIT = 8191;

endpackage

// File: rtl/mm_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing b^e mod m in the Montgomery
// domain, driving one shared Montgomery multiplier through a req/val handshake.
module mm_modexp_ctrl
   import mm_pkg::*;
#(
   parameter int unsigned K = 2048,
   parameter int unsigned E = 2048
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [K-1:0] base_mont,
   input  logic [K-1:0] one_mont,
   input  logic [E-1:0] exp,
   input  logic [K-1:0] mod_m,
   output logic         busy,
   output logic         done,
   output logic [K-1:0] result,
   output logic         mm_req,
   output logic [K-1:0] mm_x,
   output logic [K-1:0] mm_y,
   output logic [K-1:0] mm_m,
   input  logic [K-1:0] mm_res,
   input  logic         mm_val
);

   localparam int unsigned IW      = (E > 1) ? $clog2(E) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(E - 1);
   localparam logic [K-1:0]  MM_ONE  = K'(1);

   state_t        state, state_n;
   logic          waiting, waiting_n;
   logic          busy_n, done_n, mm_req_n;
   logic [K-1:0]  result_n, mm_x_n, mm_y_n, mm_m_n;
   logic [K-1:0]  acc, acc_n;
   logic [K-1:0]  base, base_n;
   logic [E-1:0]  e_reg, e_reg_n;
   logic [IW-1:0] idx, idx_n;

   logic bit_c;
   logic idx_zero_c;
   logic accept_c;

   assign bit_c      = e_reg[idx];
   assign idx_zero_c = (idx == '0);
   // A completion is only taken while an op is in flight and its launch pulse has dropped.
   assign accept_c   = waiting & ~mm_req & mm_val;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         waiting <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         mm_req  <= 1'b0;
         result  <= '0;
         mm_x    <= '0;
         mm_y    <= '0;
         mm_m    <= '0;
         acc     <= '0;
         base    <= '0;
         e_reg   <= '0;
         idx     <= IDX_TOP;
      end else begin
         state   <= state_n;
         waiting <= waiting_n;
         busy    <= busy_n;
         done    <= done_n;
         mm_req  <= mm_req_n;
         result  <= result_n;
         mm_x    <= mm_x_n;
         mm_y    <= mm_y_n;
         mm_m    <= mm_m_n;
         acc     <= acc_n;
         base    <= base_n;
         e_reg   <= e_reg_n;
         idx     <= idx_n;
      end
   end

   // Next-state and issue logic; every op is launched on the cycle its state is entered.
   always_comb begin
      state_n   = state;
      waiting_n = waiting;
      busy_n    = busy;
      done_n    = 1'b0;
      mm_req_n  = 1'b0;
      result_n  = result;
      mm_x_n    = mm_x;
      mm_y_n    = mm_y;
      mm_m_n    = mm_m;
      acc_n     = acc;
      base_n    = base;
      e_reg_n   = e_reg;
      idx_n     = idx;

      case (state)
         IDLE: begin
            if (start) begin
               base_n  = base_mont;
               acc_n   = one_mont;
               e_reg_n = exp;
               mm_m_n  = mod_m;
               idx_n   = IDX_TOP;
               busy_n  = 1'b1;
               state_n = SCAN;
            end
         end

         SCAN: begin
            if (bit_c) begin
               mm_x_n    = acc;
               mm_y_n    = acc;
               mm_req_n  = 1'b1;
               waiting_n = 1'b1;
               state_n   = SQR;
            end else if (idx_zero_c) begin
               mm_x_n    = acc;
               mm_y_n    = MM_ONE;
               mm_req_n  = 1'b1;
               waiting_n = 1'b1;
               state_n   = OUT;
            end else begin
               idx_n = idx - IW'(1);
            end
         end

         SQR: begin
            if (accept_c) begin
               acc_n     = mm_res;
               mm_req_n  = 1'b1;
               waiting_n = 1'b1;
               if (bit_c) begin
                  mm_x_n  = mm_res;
                  mm_y_n  = base;
                  state_n = MUL;
               end else if (idx_zero_c) begin
                  mm_x_n  = mm_res;
                  mm_y_n  = MM_ONE;
                  state_n = OUT;
               end else begin
                  idx_n   = idx - IW'(1);
                  mm_x_n  = mm_res;
                  mm_y_n  = mm_res;
                  state_n = SQR;
               end
            end
         end

         MUL: begin
            if (accept_c) begin
               acc_n     = mm_res;
               mm_req_n  = 1'b1;
               waiting_n = 1'b1;
               if (idx_zero_c) begin
                  mm_x_n  = mm_res;
                  mm_y_n  = MM_ONE;
                  state_n = OUT;
               end else begin
                  idx_n   = idx - IW'(1);
                  mm_x_n  = mm_res;
                  mm_y_n  = mm_res;
                  state_n = SQR;
               end
            end
         end

         OUT: begin
            if (accept_c) begin
               result_n  = mm_res;
               done_n    = 1'b1;
               busy_n    = 1'b0;
               waiting_n = 1'b0;
               state_n   = IDLE;
            end
         end

         default: begin
            state_n   = IDLE;
            waiting_n = 1'b0;
            busy_n    = 1'b0;
         end
      endcase
   end

endmodule
